// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: instruction field
// codes, ALU_control encodings, mux select codes and FSM state encodings.
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU_control codes understood by the ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU B operand select
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_BR   = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Controller states; encodings 12..15 are unreachable
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11
    } state_t;

    // What kind of ALU operation the current state asks for
    typedef enum logic [2:0] {
        ALU_CLS_NONE  = 3'd0,
        ALU_CLS_ADD   = 3'd1,
        ALU_CLS_SUB   = 3'd2,
        ALU_CLS_RTYPE = 3'd3,
        ALU_CLS_ITYPE = 3'd4
    } alu_cls_t;

    // Logical immediates are zero-extended, arithmetic ones sign-extended
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// ALU_control decoder: maps the operation class requested by the controller
// plus the IR opcode/funct fields onto the 4-bit ALU_control code.
module mips_alu_decode
    import mips_pkg::*;
(
    input  alu_cls_t    alu_cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_control,
    output logic        funct_valid
);

    // funct is a supported R-type operation (independent of class)
    always_comb begin
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: funct_valid = 1'b1;
            default:                                        funct_valid = 1'b0;
        endcase
    end

    // Select the ALU operation; unknown codes fall back to AND (0000)
    always_comb begin
        alu_control = ALU_AND;
        case (alu_cls)
            ALU_CLS_ADD: alu_control = ALU_ADD;
            ALU_CLS_SUB: alu_control = ALU_SUB;
            ALU_CLS_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_NOR:  alu_control = ALU_NOR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            ALU_CLS_ITYPE: begin
                case (opcode)
                    OP_ADDI: alu_control = ALU_ADD;
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    OP_SLTI: alu_control = ALU_SLT;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller. Outputs are decoded from the state
// register (pc_en/ir_write also look at mem_ready in FETCH and zero in
// BRANCH) and are all forced low while rst is high, so no write enable can
// fire in a reset cycle even if the FSM was mid-instruction.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter bit RESET_PC_HOLD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        zero_ext,
    output logic [1:0]  pc_source,
    output logic [3:0]  ALU_control,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t   state_reg, state_next;
    logic     illegal_reg, illegal_next;
    logic     first_fetch_reg;
    alu_cls_t alu_cls;
    logic [3:0] alu_control_dec;
    logic     funct_valid;
    logic     pc_hold;

    mips_alu_decode u_alu_decode (
        .alu_cls     (alu_cls),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (alu_control_dec),
        .funct_valid (funct_valid)
    );

    // Only the very first FETCH after reset suppresses the PC update
    assign pc_hold = RESET_PC_HOLD && first_fetch_reg;

    assign state   = state_reg;
    assign illegal = illegal_reg;

    // Next-state logic; IR fields are only consulted from DECODE onward
    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     state_next = ST_MEM_ADDR;
                    OP_RTYPE:                         state_next = ST_R_EXEC;
                    OP_BEQ, OP_BNE:                   state_next = ST_BRANCH;
                    OP_J:                             state_next = ST_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = ST_I_EXEC;
                    default: begin
                        state_next   = ST_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                if (mem_ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_R_EXEC: begin
                if (funct_valid) begin
                    state_next = ST_R_WB;
                end else begin
                    state_next   = ST_FETCH;
                    illegal_next = 1'b1;
                end
            end
            ST_I_EXEC: state_next = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_I_WB: state_next = ST_FETCH;
            default:   state_next = ST_FETCH;
        endcase
    end

    // State, sticky illegal flag and first-fetch marker
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_FETCH;
            illegal_reg     <= 1'b0;
            first_fetch_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            if (state_reg == ST_FETCH && mem_ready) first_fetch_reg <= 1'b0;
        end
    end

    // Which ALU operation each state requests
    always_comb begin
        case (state_reg)
            ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_cls = ALU_CLS_ADD;
            ST_BRANCH:                        alu_cls = ALU_CLS_SUB;
            ST_R_EXEC:                        alu_cls = ALU_CLS_RTYPE;
            ST_I_EXEC:                        alu_cls = ALU_CLS_ITYPE;
            default:                          alu_cls = ALU_CLS_NONE;
        endcase
    end

    // Control output decode; everything low in reset and in unused encodings
    always_comb begin
        pc_en       = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_REG;
        zero_ext    = 1'b0;
        pc_source   = PC_SRC_ALU;
        ALU_control = ALU_AND;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_read    = 1'b1;
                    ir_write    = mem_ready;
                    alu_src_b   = SRC_B_FOUR;
                    ALU_control = alu_control_dec;
                    pc_en       = mem_ready && !pc_hold;
                end
                ST_DECODE: begin
                    alu_src_b   = SRC_B_BR;
                    ALU_control = alu_control_dec;
                end
                ST_MEM_ADDR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = SRC_B_IMM;
                    ALU_control = alu_control_dec;
                end
                ST_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                ST_R_EXEC: begin
                    alu_src_a   = 1'b1;
                    ALU_control = alu_control_dec;
                end
                ST_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a   = 1'b1;
                    ALU_control = alu_control_dec;
                    pc_source   = PC_SRC_ALUOUT;
                    pc_en       = (opcode == OP_BNE) ? !zero : zero;
                end
                ST_JUMP: begin
                    pc_source = PC_SRC_JUMP;
                    pc_en     = 1'b1;
                end
                ST_I_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = SRC_B_IMM;
                    zero_ext    = is_zero_ext_op(opcode);
                    ALU_control = alu_control_dec;
                end
                ST_I_WB: begin
                    reg_write = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control. The stimulus process drives one cycle
// at a time and queues the hand-derived expected output vector for it; the
// monitor pops and compares on every falling edge.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] ALU_control, state;

    always #5 clk = ~clk;

    mips_mc_control #(.RESET_PC_HOLD(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .zero_ext    (zero_ext),
        .pc_source   (pc_source),
        .ALU_control (ALU_control),
        .illegal     (illegal),
        .state       (state)
    );

    // {pc_en,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,
    //  alu_src_a,alu_src_b[1:0],zero_ext,pc_source[1:0],ALU_control[3:0],
    //  illegal,state[3:0]}
    logic [22:0] act;
    assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
                  pc_source, ALU_control, illegal, state};

    localparam logic [22:0] MASK_ALL      = 23'h7FFFFF;
    localparam logic [22:0] MASK_NO_STATE = 23'h7FFFF0;
    localparam logic [22:0] MASK_NO_ILL   = 23'h7FFFEF;

    typedef struct {
        string       nm;
        logic [22:0] vec;
        logic [22:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic il = 1'b0;   // expected sticky illegal flag

    function automatic logic [22:0] v(
        input logic pe, input logic io, input logic mr, input logic mw,
        input logic irw, input logic m2r, input logic rd, input logic rw,
        input logic sa, input logic [1:0] sb, input logic ze,
        input logic [1:0] ps, input logic [3:0] ac, input logic ill,
        input logic [3:0] st);
        return {pe, io, mr, mw, irw, m2r, rd, rw, sa, sb, ze, ps, ac, ill, st};
    endfunction

    // Expected outputs of each state, taken from the control table
    function automatic logic [22:0] e_fetch(input logic rdy);
        return v(rdy,0,1,0,rdy,0,0,0,0,2'b01,0,2'b00,4'b0010,il,4'd0);
    endfunction
    function automatic logic [22:0] e_decode();
        return v(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,4'b0010,il,4'd1);
    endfunction
    function automatic logic [22:0] e_memaddr();
        return v(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,4'b0010,il,4'd2);
    endfunction
    function automatic logic [22:0] e_memread();
        return v(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,il,4'd3);
    endfunction
    function automatic logic [22:0] e_memwb();
        return v(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,4'b0000,il,4'd4);
    endfunction
    function automatic logic [22:0] e_memwrite();
        return v(0,1,0,1,0,0,0,0,0,2'b00,0,2'b00,4'b0000,il,4'd5);
    endfunction
    function automatic logic [22:0] e_rexec(input logic [3:0] ac);
        return v(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,ac,il,4'd6);
    endfunction
    function automatic logic [22:0] e_rwb();
        return v(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,4'b0000,il,4'd7);
    endfunction
    function automatic logic [22:0] e_branch(input logic pe);
        return v(pe,0,0,0,0,0,0,0,1,2'b00,0,2'b01,4'b0110,il,4'd8);
    endfunction
    function automatic logic [22:0] e_jump();
        return v(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,4'b0000,il,4'd9);
    endfunction
    function automatic logic [22:0] e_iexec(input logic ze, input logic [3:0] ac);
        return v(0,0,0,0,0,0,0,0,1,2'b10,ze,2'b00,ac,il,4'd10);
    endfunction
    function automatic logic [22:0] e_iwb();
        return v(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,4'b0000,il,4'd11);
    endfunction

    // Queue the expectation for the current cycle, then advance one cycle
    task automatic cycm(input string nm, input logic [22:0] e, input logic [22:0] m);
        exp_t x;
        x.nm   = nm;
        x.vec  = e;
        x.mask = m;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [22:0] e);
        cycm(nm, e, MASK_ALL);
    endtask

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            compared++;
            if ((act & x.mask) !== (x.vec & x.mask)) begin
                mismatched++;
                $display("FAIL %s: actual %06h required %06h (mask %06h)",
                         x.nm, act, x.vec, x.mask);
            end else begin
                $display("ok   %s: %06h", x.nm, act);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_hold", 23'h0);
        rst = 1'b0;

        // sub: 4 cycles, back in FETCH on cycle 5
        opcode = 6'h00; funct = 6'h22;
        cyc("sub_fetch", e_fetch(1));
        cyc("sub_decode", e_decode());
        cyc("sub_exec", e_rexec(4'b0110));
        cyc("sub_wb", e_rwb());

        // lw with three memory wait cycles
        opcode = 6'h23;
        cyc("lw_fetch", e_fetch(1));
        cyc("lw_decode", e_decode());
        cyc("lw_addr", e_memaddr());
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_read_wait", e_memread());
        mem_ready = 1'b1;
        cyc("lw_read_done", e_memread());
        cyc("lw_wb", e_memwb());

        // reset while in MEM_WB: no reg_write in the reset cycle
        cyc("lw2_fetch", e_fetch(1));
        cyc("lw2_decode", e_decode());
        cyc("lw2_addr", e_memaddr());
        cyc("lw2_read", e_memread());
        rst = 1'b1;
        cycm("rst_mid_wb", 23'h0, MASK_NO_STATE);
        cyc("rst_mid_hold", 23'h0);
        rst = 1'b0;

        // branches
        opcode = 6'h04; zero = 1'b1;
        cyc("beq_fetch", e_fetch(1));
        cyc("beq_decode", e_decode());
        cyc("beq_taken", e_branch(1));
        opcode = 6'h05;
        cyc("bne_fetch", e_fetch(1));
        cyc("bne_decode", e_decode());
        cyc("bne_not_taken", e_branch(0));
        zero = 1'b0;
        cyc("bne2_fetch", e_fetch(1));
        cyc("bne2_decode", e_decode());
        cyc("bne2_taken", e_branch(1));

        // I-type
        opcode = 6'h0D;
        cyc("ori_fetch", e_fetch(1));
        cyc("ori_decode", e_decode());
        cyc("ori_exec", e_iexec(1, 4'b0001));
        cyc("ori_wb", e_iwb());
        opcode = 6'h0A;
        cyc("slti_fetch", e_fetch(1));
        cyc("slti_decode", e_decode());
        cyc("slti_exec", e_iexec(0, 4'b0111));
        cyc("slti_wb", e_iwb());
        opcode = 6'h0C;
        cyc("andi_fetch", e_fetch(1));
        cyc("andi_decode", e_decode());
        cyc("andi_exec", e_iexec(1, 4'b0000));
        cyc("andi_wb", e_iwb());

        // sw with a fetch stall (IR junk ignored) and one write wait cycle
        mem_ready = 1'b0; opcode = 6'h3F;
        cyc("sw_fetch_wait", e_fetch(0));
        opcode = 6'h00;
        cyc("sw_fetch_wait", e_fetch(0));
        opcode = 6'h2B; mem_ready = 1'b1;
        cyc("sw_fetch", e_fetch(1));
        cyc("sw_decode", e_decode());
        cyc("sw_addr", e_memaddr());
        mem_ready = 1'b0;
        cyc("sw_write_wait", e_memwrite());
        mem_ready = 1'b1;
        cyc("sw_write_done", e_memwrite());

        // jump
        opcode = 6'h02;
        cyc("j_fetch", e_fetch(1));
        cyc("j_decode", e_decode());
        cyc("j_jump", e_jump());

        // illegal funct: no R_WB, flag sets and persists
        opcode = 6'h00; funct = 6'h3F;
        cyc("badfn_fetch", e_fetch(1));
        cyc("badfn_decode", e_decode());
        cyc("badfn_exec", e_rexec(4'b0000));
        il = 1'b1;
        funct = 6'h20;
        cyc("add_fetch", e_fetch(1));
        cyc("add_decode", e_decode());
        cyc("add_exec", e_rexec(4'b0010));
        cyc("add_wb", e_rwb());

        // only reset clears the flag
        rst = 1'b1;
        cycm("rst_clear", 23'h0, MASK_NO_ILL);
        il = 1'b0;
        cyc("rst_clear_hold", 23'h0);
        rst = 1'b0;

        // illegal opcode: straight back to FETCH with illegal set
        opcode = 6'h3F;
        cyc("badop_fetch", e_fetch(1));
        cyc("badop_decode", e_decode());
        il = 1'b1;
        opcode = 6'h02;
        cyc("badop_next_fetch", e_fetch(1));
        cyc("j2_decode", e_decode());
        cyc("j2_jump", e_jump());
        cyc("end_fetch", e_fetch(1));

        // let the monitor drain, bounded
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM plus ALU-control decode: the producing end of the 4-bit ALU_control / zero interface.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives datapath mux selects, write enables and ALU_control; consumes the ALU zero flag for branches.
- Sits between the instruction register, the memory interface and the datapath (register file, ALU, PC).

Parameters:
- RESET_PC_HOLD, 0, when 1, pc_en stays low in the first FETCH after reset (bring-up aid).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (result==0)
- mem_ready  in  1  memory access complete this cycle
- pc_en  out  1  PC write enable, includes branch condition
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- zero_ext  out  1  immediate zero-extend (andi/ori)
- pc_source  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- ALU_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- illegal  out  1  sticky flag: unknown opcode or funct seen
- state  out  4  current state (debug)

Behaviour:
- Reset
  - While rst=1: state<=FETCH, illegal<=0, every control output driven 0, including ALU_control=0000.
  - rst mid-instruction aborts it. No write enable may assert in the reset cycle.
- Outputs are Moore-decoded from the state register. Exception: pc_en also depends on zero in BRANCH.
- States:
  - FETCH: mem_read=1, i_or_d=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=01, ADD, pc_source=00, pc_en=mem_ready. Holds while mem_ready=0; goes to DECODE on mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x00 -> R_EXEC
    - 0x04 or 0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x08, 0x0C, 0x0D, 0x0A -> I_EXEC
    - any other opcode -> illegal<=1, FETCH
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, ALU_control from funct:
    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT
    - any other funct: ALU_control=0000, illegal<=1, next state FETCH (no writeback)
    - valid funct: next state R_WB
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01.
    - beq: pc_en = zero.
    - bne: pc_en = ~zero.
    - Then FETCH.
  - JUMP: pc_source=10, pc_en=1. Then FETCH.
  - I_EXEC: alu_src_a=1, alu_src_b=10, zero_ext=1 for andi/ori only.
    - ALU op: addi ADD, andi AND, ori OR, slti SLT.
    - Then I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- opcode and funct must be sampled only from DECODE onward; a changing IR during FETCH is ignored.
- Latency with mem_ready tied 1:
  - R-type 4 cycles, I-type 4, lw 5, sw 4, beq/bne 3, j 3.
  - Each mem_ready=0 cycle adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Handshake:
  - mem_read/mem_write hold steady until the cycle in which mem_ready=1. They drop the following cycle.
  - mem_read and mem_write are never asserted together.
- illegal clears only on rst.
- Any unreachable state encoding goes to FETCH, with all outputs 0 for that cycle.

Decomposition:
- Shared package mips_pkg:
  - opcode and funct localparams
  - ALU_control codes (the six above)
  - state encodings
  - alu_src_b and pc_source select codes
- One combinational sub-module, mips_alu_decode: (state-class, opcode, funct) -> ALU_control, funct_valid. This keeps ALU code mapping in one place, shared with the ALU side.

Test Plan:
- Reset: rst=1 for 2 cycles with opcode=0x23 -> all outputs 0, state=FETCH. After release, mem_read=1 and alu_src_b=01 in cycle 1.
- R-type: opcode=0x00, funct=0x22, mem_ready=1 -> R_EXEC shows ALU_control=0110. R_WB shows reg_write=1, reg_dst=1. Back in FETCH at cycle 5.
- lw with wait: opcode=0x23, mem_ready low 3 cycles in MEM_READ -> mem_read and i_or_d stay high for 4 cycles. reg_write=1 with mem_to_reg=1 one cycle after mem_ready.
- Branches: beq with zero=1 -> pc_en=1 and pc_source=01 in BRANCH. bne with zero=1 -> pc_en=0. Both take 3 cycles total.
- I-type: ori (0x0D) -> ALU_control=0001, zero_ext=1, alu_src_b=10. slti (0x0A) -> 0111, zero_ext=0.
- Illegal: opcode=0x3F -> illegal=1 after DECODE, no reg_write/mem_write, returns to FETCH. Funct=0x3F on an R-type -> illegal=1, no R_WB. Flag persists until rst.
